// File: rtl/fuzzy_wavelet_pkg.sv
// Shared definitions for the fuzzy wavelet sample path: tx state encoding and sample width.
package fuzzy_wavelet_pkg;

  localparam int unsigned TX_BITS_PER_ELEM = 8;

  localparam logic [1:0] TX_IDLE      = 2'd0;
  localparam logic [1:0] TX_SETUP     = 2'd1;
  localparam logic [1:0] TX_STROBE_HI = 2'd2;
  localparam logic [1:0] TX_HOLD_LO   = 2'd3;

endpackage

// File: rtl/sample_stream_tx_if.sv
// Byte valid/ready source bus feeding sample_stream_tx.
interface sample_stream_tx_if
  import fuzzy_wavelet_pkg::*;
#(
  parameter int unsigned W = TX_BITS_PER_ELEM
);
  logic         valid;
  logic [W-1:0] data;
  logic         ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with show-ahead read data; writes on full and reads on empty are ignored.
module sample_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [W-1:0]               i_wr_data,
  input  logic                       i_rd_en,
  output logic [W-1:0]               o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_wr      = i_wr_en & ~o_full;
  assign w_rd      = i_rd_en & ~o_empty;

  // Storage array, written without reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end
endmodule

// File: rtl/sample_stream_tx.sv
// Turns a byte stream (or an internal ramp) into strobed samples for the chip's sample port.
module sample_stream_tx
  import fuzzy_wavelet_pkg::*;
#(
  parameter int unsigned BITS_PER_ELEM = TX_BITS_PER_ELEM,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned HIGH_CYCLES   = 2,
  parameter int unsigned LOW_CYCLES    = 2
)(
  input  logic                     clk,
  input  logic                     rst,
  sample_stream_tx_if.slave        src_if,
  input  logic                     i_pattern_en,
  output logic [BITS_PER_ELEM-1:0] o_value,
  output logic                     o_data_clk,
  output logic                     o_busy,
  output logic [15:0]              o_sent
);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned MAX_A = (SETUP_CYCLES > HIGH_CYCLES) ? SETUP_CYCLES : HIGH_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > LOW_CYCLES) ? MAX_A : LOW_CYCLES;
  localparam int unsigned PW    = $clog2(MAX_C + 1);

  logic [1:0]               r_state;
  logic [PW-1:0]            r_phase;
  logic [BITS_PER_ELEM-1:0] r_value;
  logic [BITS_PER_ELEM-1:0] r_ramp;
  logic                     r_data_clk;
  logic                     r_busy;
  logic                     r_ready;
  logic [15:0]              r_sent;

  logic [1:0]               w_state_nxt;
  logic [PW-1:0]            w_phase_nxt;
  logic                     w_load;
  logic                     w_have_src;
  logic                     w_pop;
  logic                     w_take_ramp;
  logic                     w_wr;
  logic                     w_full;
  logic                     w_empty;
  logic [CW-1:0]            w_count;
  logic [CW-1:0]            w_count_nxt;
  logic [BITS_PER_ELEM-1:0] w_fifo_data;

  assign w_wr        = src_if.valid & r_ready & ~w_full;
  assign w_pop       = w_load & ~i_pattern_en;
  assign w_take_ramp = w_load & i_pattern_en;
  assign w_count_nxt = w_count + CW'(w_wr) - CW'(w_pop);

  assign src_if.ready = r_ready;
  assign o_value      = r_value;
  assign o_data_clk   = r_data_clk;
  assign o_busy       = r_busy;
  assign o_sent       = r_sent;

  sample_fifo #(
    .W     (BITS_PER_ELEM),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr),
    .i_wr_data (src_if.data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // Next state and phase; w_load marks an edge that fetches a new sample.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_load      = 1'b0;
    w_have_src  = i_pattern_en | ~w_empty;
    case (r_state)
      TX_IDLE: begin
        if (w_have_src) begin
          w_state_nxt = TX_SETUP;
          w_phase_nxt = PW'(SETUP_CYCLES - 1);
          w_load      = 1'b1;
        end
      end
      TX_SETUP: begin
        if (r_phase == '0) begin
          w_state_nxt = TX_STROBE_HI;
          w_phase_nxt = PW'(HIGH_CYCLES - 1);
        end else begin
          w_phase_nxt = r_phase - PW'(1);
        end
      end
      TX_STROBE_HI: begin
        if (r_phase == '0) begin
          w_state_nxt = TX_HOLD_LO;
          w_phase_nxt = PW'(LOW_CYCLES - 1);
        end else begin
          w_phase_nxt = r_phase - PW'(1);
        end
      end
      TX_HOLD_LO: begin
        if (r_phase == '0) begin
          if (w_have_src) begin
            w_state_nxt = TX_SETUP;
            w_phase_nxt = PW'(SETUP_CYCLES - 1);
            w_load      = 1'b1;
          end else begin
            w_state_nxt = TX_IDLE;
            w_phase_nxt = '0;
          end
        end else begin
          w_phase_nxt = r_phase - PW'(1);
        end
      end
      default: begin
        w_state_nxt = TX_IDLE;
        w_phase_nxt = '0;
      end
    endcase
  end

  // State, sample value, strobe and counters; strobe and value come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= TX_IDLE;
      r_phase    <= '0;
      r_value    <= '0;
      r_ramp     <= '0;
      r_data_clk <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
      r_sent     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_data_clk <= (w_state_nxt == TX_STROBE_HI);
      r_busy     <= (w_state_nxt != TX_IDLE);
      r_ready    <= (w_count_nxt != CW'(FIFO_DEPTH));
      if (w_pop)       r_value <= w_fifo_data;
      if (w_take_ramp) begin
        r_value <= r_ramp;
        r_ramp  <= r_ramp + BITS_PER_ELEM'(1);
      end
      if (r_state == TX_SETUP && w_state_nxt == TX_STROBE_HI) r_sent <= r_sent + 16'd1;
    end
  end
endmodule

// File: tb/tb_sample_stream_tx.sv
// Directed bench for sample_stream_tx: reset, single byte, burst/backpressure, ramp mode, reset mid-strobe.
module tb_sample_stream_tx;
  logic        clk;
  logic        rst;
  logic        i_pattern_en;
  logic [7:0]  o_value;
  logic        o_data_clk;
  logic        o_busy;
  logic [15:0] o_sent;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] got[$];
  int         ts[$];
  logic       prev_dclk = 1'b0;
  logic [7:0] prev_val  = 8'h00;

  sample_stream_tx_if #(.W(8)) src ();

  sample_stream_tx dut (
    .clk          (clk),
    .rst          (rst),
    .src_if       (src),
    .i_pattern_en (i_pattern_en),
    .o_value      (o_value),
    .o_data_clk   (o_data_clk),
    .o_busy       (o_busy),
    .o_sent       (o_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Strobe monitor: value must hold while the strobe is high and across the rising edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_dclk = 1'b0;
      prev_val  = o_value;
    end else begin
      if (o_data_clk) begin
        total++;
        assert (o_value === prev_val) else begin
          bad++;
          $error("FAIL stable_value observed=%0h expected=%0h", o_value, prev_val);
        end
      end
      if (o_data_clk && !prev_dclk) begin
        got.push_back(o_value);
        ts.push_back(cyc);
      end
      prev_dclk = o_data_clk;
      prev_val  = o_value;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (o_busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int         n;
    int         idx;
    int         errs;
    logic       rdy;
    logic [7:0] expv;

    rst          = 1'b1;
    src.valid    = 1'b0;
    src.data     = 8'h00;
    i_pattern_en = 1'b0;

    // Reset state
    tick();
    chk("rst_ready", 32'(src.ready), 32'd0);
    chk("rst_dclk",  32'(o_data_clk), 32'd0);
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_sent",  32'(o_sent), 32'd0);
    chk("rst_value", 32'(o_value), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rel_ready", 32'(src.ready), 32'd1);

    // Single byte A5
    src.valid = 1'b1;
    src.data  = 8'hA5;
    tick();
    src.valid = 1'b0;
    chk("one_busy0", 32'(o_busy), 32'd0);
    tick();
    chk("one_value", 32'(o_value), 32'hA5);
    chk("one_busy1", 32'(o_busy), 32'd1);
    chk("one_dclk_setup", 32'(o_data_clk), 32'd0);
    tick();
    chk("one_dclk_rise", 32'(o_data_clk), 32'd1);
    chk("one_sent", 32'(o_sent), 32'd1);
    tick();
    chk("one_dclk_hi2", 32'(o_data_clk), 32'd1);
    tick();
    chk("one_dclk_fall", 32'(o_data_clk), 32'd0);
    tick();
    chk("one_busy_lo", 32'(o_busy), 32'd1);
    tick();
    chk("one_idle", 32'(o_busy), 32'd0);
    chk("one_sent_end", 32'(o_sent), 32'd1);

    // Burst 10..15 with valid held
    got.delete();
    ts.delete();
    idx = 0;
    n   = 0;
    src.valid = 1'b1;
    while (idx < 6 && n < 60) begin
      src.data = 8'(8'h10 + idx);
      rdy = src.ready;
      tick();
      n++;
      if (rdy) idx++;
      if (n == 5) chk("burst_ready_low", 32'(src.ready), 32'd0);
    end
    src.valid = 1'b0;
    chk("burst_written", 32'(idx), 32'd6);
    wait_idle(100);
    chk("burst_idle", 32'(o_busy), 32'd0);
    chk("burst_count", 32'(got.size()), 32'd6);
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      expv = 8'(8'h10 + i);
      if (i >= got.size() || got[i] !== expv) errs++;
      if (i > 0 && i < ts.size() && (ts[i] - ts[i-1]) != 5) errs++;
    end
    chk("burst_order_period", 32'(errs), 32'd0);
    chk("burst_sent", 32'(o_sent), 32'd7);

    // Ramp mode, 600 samples, with a FIFO byte written mid-run
    got.delete();
    ts.delete();
    i_pattern_en = 1'b1;
    n = 0;
    while (got.size() < 600 && n < 4000) begin
      tick();
      n++;
      if (n == 10) begin
        src.valid = 1'b1;
        src.data  = 8'h3C;
      end
      if (n == 11) src.valid = 1'b0;
    end
    i_pattern_en = 1'b0;
    chk("ramp_reached", 32'(got.size()), 32'd600);
    wait_idle(100);
    chk("ramp_idle", 32'(o_busy), 32'd0);
    chk("ramp_total", 32'(got.size()), 32'd601);
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      expv = 8'(i);
      if (i >= got.size() || got[i] !== expv) errs++;
    end
    chk("ramp_seq", 32'(errs), 32'd0);
    chk("ramp_ff",   32'(got[255]), 32'hFF);
    chk("ramp_wrap", 32'(got[256]), 32'h00);
    chk("ramp_last", 32'(got[599]), 32'h57);
    chk("fifo_after_ramp", 32'(got[600]), 32'h3C);
    chk("ramp_sent", 32'(o_sent), 32'd608);

    // Reset while the strobe is high; FIFO contents are dropped
    got.delete();
    ts.delete();
    src.valid = 1'b1;
    src.data  = 8'h77;
    tick();
    src.data  = 8'h88;
    tick();
    src.valid = 1'b0;
    n = 0;
    while (o_data_clk !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("mid_dclk_hi", 32'(o_data_clk), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_dclk", 32'(o_data_clk), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rel_sent",  32'(o_sent), 32'd0);
    chk("mid_rel_busy",  32'(o_busy), 32'd0);
    chk("mid_rel_ready", 32'(src.ready), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("mid_no_resume", 32'(o_busy), 32'd0);
    chk("mid_no_strobe", 32'(got.size()), 32'd0);
    chk("mid_sent_zero", 32'(o_sent), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
